// File: rtl/morse_tx_sequencer.sv
// Streams buffered Morse character codes into the single-shot transmitter via start/busy.
// Optional MORSE_SEQ_AUTOSPACE_EN appends a word gap (code 0) whenever the queue drains after a letter.
module morse_tx_sequencer #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [4:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    input  logic                     run,
    output logic                     tx_start,
    output logic [4:0]               tx_char,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     active,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e          state_q, state_d;
    logic [4:0]      mem_q [DEPTH];
    logic [4:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tx_start_q, tx_start_d;
    logic [4:0]      tx_char_q, tx_char_d;
    logic [7:0]      timer_q, timer_d;
    logic            timeout_err_q, timeout_err_d;
`ifdef MORSE_SEQ_AUTOSPACE_EN
    logic            need_space_q, need_space_d;
`endif

    logic            full, empty, do_write, pop, issue;
    logic [4:0]      issue_char;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        do_write   = wr_valid && !full && !flush;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_char = 5'd0;

        state_d       = state_q;
        tx_start_d    = 1'b0;
        tx_char_d     = tx_char_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
`ifdef MORSE_SEQ_AUTOSPACE_EN
        need_space_d  = need_space_q;
`endif

        // A flush in IDLE also suppresses the issue so flushed data never leaks out.
        case (state_q)
            IDLE: begin
                if (run && !flush) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        issue      = 1'b1;
                        issue_char = mem_q[rd_ptr_q];
                    end
`ifdef MORSE_SEQ_AUTOSPACE_EN
                    else if (need_space_q) begin
                        issue      = 1'b1;
                        issue_char = 5'd0;
                    end
`endif
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == 8'(BUSY_TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            tx_char_d  = issue_char;
            tx_start_d = 1'b1;
            timer_d    = 8'd0;
            state_d    = WAIT_BUSY;
`ifdef MORSE_SEQ_AUTOSPACE_EN
            need_space_d = (issue_char != 5'd0);
`endif
        end

        mem_d = mem_q;
        if (do_write) mem_d[wr_ptr_q] = wr_data;

        wr_ptr_d = wr_ptr_q + AW'(do_write);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(do_write) - CW'(pop);

        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            timeout_err_d = 1'b0;
`ifdef MORSE_SEQ_AUTOSPACE_EN
            need_space_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tx_start_q    <= 1'b0;
            tx_char_q     <= 5'd0;
            timer_q       <= 8'd0;
            timeout_err_q <= 1'b0;
`ifdef MORSE_SEQ_AUTOSPACE_EN
            need_space_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tx_start_q    <= tx_start_d;
            tx_char_q     <= tx_char_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
`ifdef MORSE_SEQ_AUTOSPACE_EN
            need_space_q  <= need_space_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wr_ready    = !full;
    assign tx_start    = tx_start_q;
    assign tx_char     = tx_char_q;
    assign fifo_count  = count_q;
    assign active      = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer: a cycle table plus hand sequences with a transmitter model.
// Build with MORSE_SEQ_AUTOSPACE_EN to cover the word-gap variant.
module tb_morse_tx_sequencer;
    localparam int DEPTH = 8;
    localparam int BT    = 15;

    logic       clk = 1'b0;
    logic       rst, wr_valid, flush, run, tx_busy;
    logic [4:0] wr_data;
    logic       wr_ready, tx_start, active, timeout_err;
    logic [4:0] tx_char;
    logic [3:0] fifo_count;

    morse_tx_sequencer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush(flush), .run(run), .tx_start(tx_start), .tx_char(tx_char), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int matched = 0;
    int auto_cnt = 0;
    logic [4:0] exp_q[$];
    int pulse_cyc_q[$];
    int pulse_cnt_q[$];
    bit model_en = 1'b0;
    bit no_busy  = 1'b0;
    int busy_len = 10;
    int busy_cnt = 0;

    typedef struct {
        logic       wv;
        logic [4:0] wd;
        logic       fl;
        logic       busy;
        logic       es;
        logic [4:0] ec;
        logic [3:0] en;
        logic       ea;
    } vec_t;
    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; also plays the transmitter and scores every start pulse.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_start) begin
                pulse_cyc_q.push_back(cyc);
                pulse_cnt_q.push_back(int'(fifo_count));
`ifdef MORSE_SEQ_AUTOSPACE_EN
                if (tx_char == 5'd0 && (exp_q.size() == 0 || exp_q[0] != 5'd0)) auto_cnt++;
                else
`endif
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got char %0d expected no pulse (cycle %0d)", tx_char, cyc);
                end else begin
                    check("pulse_char", tx_char, exp_q.pop_front());
                    matched++;
                end
                if (!no_busy) begin
                    tx_busy  = 1'b1;
                    busy_cnt = busy_len;
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input int max_cyc);
        int stable = 0;
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            step();
            if (!active && fifo_count == 0) stable++;
            else stable = 0;
            if (stable == 3) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", max_cyc);
        end
    endtask

    task automatic write1(input logic [4:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_char"}, tx_char, 0);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int m0, t_err, exp_pulses;
        bit got_err;

        vt[0]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd5 & 5'd0, 4'd1, 1'b0};
        vt[1]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  4'd0, 1'b1};
        vt[2]  = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd5,  4'd0, 1'b1};
        vt[3]  = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd5,  4'd0, 1'b1};
        vt[4]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  4'd0, 1'b0};
        vt[5]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  4'd0, 1'b0};
        vt[6]  = '{1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 5'd5,  4'd1, 1'b0};
        vt[7]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd31, 4'd0, 1'b1};
        vt[8]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd31, 4'd0, 1'b1};
        vt[9]  = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd31, 4'd0, 1'b1};
        vt[10] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd31, 4'd0, 1'b0};
        vt[11] = '{1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 5'd31, 4'd1, 1'b0};
        vt[12] = '{1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 5'd1,  4'd1, 1'b1};
        vt[13] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd1,  4'd1, 1'b1};
        vt[14] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd1,  4'd1, 1'b0};
        vt[15] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd2,  4'd0, 1'b1};
        vt[16] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd2,  4'd0, 1'b1};
        vt[17] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd2,  4'd0, 1'b0};

        // Clock/reset
        rst = 1'b1; wr_valid = 1'b0; wr_data = 5'd0; flush = 1'b0; run = 1'b1; tx_busy = 1'b0;
        step();
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Cycle-exact table: single char, code 31 passthrough, write+pop in one cycle
        for (int i = 0; i < 18; i++) begin
            wr_valid = vt[i].wv;
            wr_data  = vt[i].wd;
            flush    = vt[i].fl;
            tx_busy  = vt[i].busy;
            step();
            check($sformatf("vec%0d_tx_start", i), tx_start, vt[i].es);
            check($sformatf("vec%0d_tx_char", i), tx_char, vt[i].ec);
            check($sformatf("vec%0d_fifo_count", i), fifo_count, vt[i].en);
            check($sformatf("vec%0d_active", i), active, vt[i].ea);
        end
        wr_valid = 1'b0; flush = 1'b0; tx_busy = 1'b0;
        model_en = 1'b1;

        // Back-to-back C, A, S with 10-cycle busy
        busy_len = 10;
        pulse_cyc_q.delete(); pulse_cnt_q.delete();
        exp_q.push_back(5'd3); exp_q.push_back(5'd1); exp_q.push_back(5'd19);
        wr_valid = 1'b1;
        wr_data = 5'd3;  step();
        wr_data = 5'd1;  step();
        wr_data = 5'd19; step();
        wr_valid = 1'b0;
        check("b2b_count_after_writes", fifo_count, 2);
        wait_idle(200);
        check("b2b_pulses", pulse_cyc_q.size(), 3);
        if (pulse_cyc_q.size() >= 3) begin
            check("b2b_gap1", pulse_cyc_q[1] - pulse_cyc_q[0], 12);
            check("b2b_gap2", pulse_cyc_q[2] - pulse_cyc_q[1], 12);
            check("b2b_count_p1", pulse_cnt_q[0], 1);
            check("b2b_count_p2", pulse_cnt_q[1], 1);
            check("b2b_count_p3", pulse_cnt_q[2], 0);
        end

        // Fill while stopped, overflow attempt, then drain across pointer wrap
        busy_len = 2;
        run = 1'b0;
        for (int i = 0; i < DEPTH; i++) write1(5'(10 + i));
        check("full_wr_ready", wr_ready, 0);
        check("full_count", fifo_count, DEPTH);
        write1(5'd30);
        check("overflow_count", fifo_count, DEPTH);
        m0 = matched;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(5'(10 + i));
        run = 1'b1;
        wait_idle(300);
        check("drain_issued", matched - m0, DEPTH);
        check("drain_exp_left", exp_q.size(), 0);

        // Busy never arrives: timeout latency, next char still issues, flush clears error
        no_busy = 1'b1;
        pulse_cyc_q.delete();
        exp_q.push_back(5'd7);
        write1(5'd7);
        got_err = 1'b0; t_err = 0;
        for (int i = 0; i < 60 && !got_err; i++) begin
            step();
            if (timeout_err) begin
                got_err = 1'b1;
                t_err = cyc;
                check("timeout_active", active, 0);
            end
        end
        check("timeout_seen", got_err, 1);
        if (got_err && pulse_cyc_q.size() > 0)
            check("timeout_latency", t_err - pulse_cyc_q[0], BT + 1);
        m0 = matched;
        exp_q.push_back(5'd8);
        write1(5'd8);
        wait_idle(200);
        check("after_timeout_issue", matched - m0, 1);
        no_busy = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_clears_err", timeout_err, 0);

        // Flush mid WAIT_DONE with 4 queued
        busy_len = 20;
        run = 1'b0;
        for (int i = 0; i < 5; i++) write1(5'(21 + i));
        pulse_cyc_q.delete();
        m0 = matched;
        exp_q.push_back(5'd21);
        run = 1'b1;
        step();
        check("flush_pre_count", fifo_count, 4);
        steps(3);
        check("flush_pre_active", active, 1);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_count", fifo_count, 0);
        check("flush_keeps_char", active, 1);
        wait_idle(200);
        check("flush_pulses", pulse_cyc_q.size(), 1);
        check("flush_completed", matched - m0, 1);

        // Reset mid WAIT_DONE with 4 queued
        run = 1'b0;
        for (int i = 0; i < 5; i++) write1(5'(1 + i));
        exp_q.push_back(5'd1);
        run = 1'b1;
        step();
        steps(3);
        check("rst_pre_active", active, 1);
        rst = 1'b1;
        step();
        tx_busy = 1'b0; busy_cnt = 0; exp_q.delete();
        check_reset_outputs("midrst");
        rst = 1'b0;
        pulse_cyc_q.delete();
        steps(5);
        check("post_rst_pulses", pulse_cyc_q.size(), 0);
        check("post_rst_active", active, 0);

        // Single T: word gap follows only in the auto-space build
        busy_len = 3;
        pulse_cyc_q.delete();
        exp_q.push_back(5'd20);
`ifdef MORSE_SEQ_AUTOSPACE_EN
        exp_q.push_back(5'd0);
        exp_pulses = 2;
`else
        exp_pulses = 1;
`endif
        write1(5'd20);
        wait_idle(200);
        check("space_pulses", pulse_cyc_q.size(), exp_pulses);
        check("space_exp_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
